// File: rtl/uart_pkg.sv
// Shared encodings and frame-timing helpers for the UART transmit scheduler.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_WAIT   = 2'd2
  } tx_state_e;

  function automatic int unsigned bit_cycles(input int unsigned clk_freq,
                                             input int unsigned baud);
    return clk_freq / baud;
  endfunction

  // 10-bit frame (start + 8 data + stop) plus trailing idle guard bits.
  function automatic int unsigned frame_cycles(input int unsigned clk_freq,
                                               input int unsigned baud,
                                               input int unsigned guard);
    return bit_cycles(clk_freq, baud) * (10 + guard);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with registered full/empty/level reflecting this cycle's write and pop.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LVL_W = AW + 1
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic [7:0]       wr_data,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [7:0]       rd_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level,
  output logic             overflow
);

  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LVL_W-1:0] lvl_nxt;
  logic             do_wr, do_rd;

  // A pop in the same cycle frees the slot, so a write at full is still taken.
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  always_comb begin
    lvl_nxt = level;
    case ({do_wr, do_rd})
      2'b10:   lvl_nxt = level + LVL_ONE;
      2'b01:   lvl_nxt = level - LVL_ONE;
      default: lvl_nxt = level;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
      level    <= lvl_nxt;
      full     <= (lvl_nxt == LVL_FULL);
      empty    <= (lvl_nxt == '0);
      overflow <= wr_en && full && !do_rd;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Drains the byte FIFO into the UART TX path: one start strobe per byte, then
// holds off for a full frame (plus guard bits) before the next pop.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 32'd50_000_000,
  parameter int unsigned UART_BAUD  = 32'd115200,
  parameter int          FIFO_DEPTH = 16,
  parameter int unsigned GUARD_BITS = 1,
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic [7:0]       wr_data,
  input  logic             wr_en,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic [LVL_W-1:0] fifo_level,
  output logic             overflow,
  output logic             busy,
  output logic [7:0]       uart_tx_data,
  output logic             uart_tx_enable
);

  localparam int unsigned     FRAME_CYCLES = frame_cycles(CLK_FREQ, UART_BAUD, GUARD_BITS);
  localparam int              CNT_W        = cnt_width(FRAME_CYCLES);
  localparam logic [CNT_W-1:0] FRAME_LAST  = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  tx_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       head;
  logic             pop;
  logic             busy_q;
  logic [7:0]       tx_data_q;

  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .rd_en    (pop),
    .rd_data  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level),
    .overflow (overflow)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      tx_data_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      busy_q <= (state != ST_IDLE) || !fifo_empty;
      if (pop) tx_data_q <= head;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    pop            = 1'b0;
    uart_tx_enable = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = ST_STROBE;
        end
      end
      ST_STROBE: begin
        uart_tx_enable = 1'b1;
        cnt_nxt        = FRAME_LAST;
        state_nxt      = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt == '0) state_nxt = ST_IDLE;
        else           cnt_nxt   = cnt - CNT_ONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy         = busy_q;
  assign uart_tx_data = tx_data_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler at 1 MHz / 100 kbaud (110-cycle frames).
module tb_uart_tx_scheduler;

  localparam int DEPTH = 16;
  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int GAP   = 112;

  logic             clk_in = 1'b0;
  logic             rst_n  = 1'b0;
  logic [7:0]       wr_data = '0;
  logic             wr_en   = 1'b0;
  logic             fifo_full, fifo_empty, overflow, busy, uart_tx_enable;
  logic [LVL_W-1:0] fifo_level;
  logic [7:0]       uart_tx_data;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ovf_cnt = 0;
  int stb_cyc[$];
  logic [7:0] stb_dat[$];

  uart_tx_scheduler #(
    .CLK_FREQ   (32'd1_000_000),
    .UART_BAUD  (32'd100_000),
    .FIFO_DEPTH (DEPTH),
    .GUARD_BITS (1)
  ) dut (
    .clk_in         (clk_in),
    .rst_n          (rst_n),
    .wr_data        (wr_data),
    .wr_en          (wr_en),
    .fifo_full      (fifo_full),
    .fifo_empty     (fifo_empty),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .busy           (busy),
    .uart_tx_data   (uart_tx_data),
    .uart_tx_enable (uart_tx_enable)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (uart_tx_enable) begin
      stb_cyc.push_back(cyc);
      stb_dat.push_back(uart_tx_data);
    end
    if (overflow) ovf_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic wr(input int c, input logic [7:0] d);
    goto(c);
    wr_en   = 1'b1;
    wr_data = d;
    goto(c + 1);
    wr_en   = 1'b0;
  endtask

  // Holds reset for 3 edges with a write pending; returns first cycle out of reset.
  task automatic do_reset(output int b);
    @(posedge clk_in); #1;
    rst_n   = 1'b0;
    wr_en   = 1'b1;
    wr_data = 8'hFF;
    repeat (3) begin
      @(posedge clk_in); #1;
    end
    chk("rst_data",  uart_tx_data,   8'h00);
    chk("rst_en",    uart_tx_enable, 1'b0);
    chk("rst_ovf",   overflow,       1'b0);
    chk("rst_empty", fifo_empty,     1'b1);
    chk("rst_full",  fifo_full,      1'b0);
    chk("rst_level", fifo_level,     '0);
    chk("rst_busy",  busy,           1'b0);
    wr_en = 1'b0;
    rst_n = 1'b1;
    b = cyc;
    goto(b + 1);
    chk("rst_wr_ignored", fifo_empty, 1'b1);
  endtask

  initial begin
    int b, s0, o0;

    // Single byte latency and hold
    do_reset(b);
    s0 = stb_cyc.size();
    wr(b + 10, 8'hA5);
    chk("t1_lvl11",   fifo_level,     1);
    chk("t1_busy11",  busy,           1'b0);
    chk("t1_en11",    uart_tx_enable, 1'b0);
    goto(b + 12);
    chk("t1_en12",    uart_tx_enable, 1'b1);
    chk("t1_dat12",   uart_tx_data,   8'hA5);
    chk("t1_empty12", fifo_empty,     1'b1);
    chk("t1_busy12",  busy,           1'b1);
    goto(b + 13);
    chk("t1_en13",    uart_tx_enable, 1'b0);
    goto(b + 122);
    chk("t1_dat122",  uart_tx_data,   8'hA5);
    goto(b + 123);
    chk("t1_busy123", busy,           1'b1);
    goto(b + 124);
    chk("t1_busy124", busy,           1'b0);
    goto(b + 200);
    chk("t1_nstb",    stb_cyc.size() - s0, 1);
    chk("t1_stbcyc",  stb_cyc[s0] - b,     12);

    // Three-byte burst: order and spacing
    do_reset(b);
    s0 = stb_cyc.size();
    for (int i = 0; i < 3; i++) wr(b + 10 + i, 8'(i + 1));
    goto(b + 12 + 2 * GAP + 20);
    chk("t2_nstb", stb_cyc.size() - s0, 3);
    if (stb_cyc.size() - s0 == 3) begin
      chk("t2_first", stb_cyc[s0] - b, 12);
      for (int i = 0; i < 3; i++) chk("t2_dat", stb_dat[s0 + i], 8'(i + 1));
      for (int i = 1; i < 3; i++) chk("t2_gap", stb_cyc[s0 + i] - stb_cyc[s0 + i - 1], GAP);
    end

    // 17 writes while idle: fits because the first is popped at once
    do_reset(b);
    s0 = stb_cyc.size();
    o0 = ovf_cnt;
    for (int i = 0; i < 17; i++) wr(b + 10 + i, 8'(8'h10 + i));
    chk("t3_lvl", fifo_level, 16);
    chk("t3_full", fifo_full, 1'b1);
    goto(b + 12 + 16 * GAP + 20);
    chk("t3_nstb", stb_cyc.size() - s0, 17);
    chk("t3_ovf",  ovf_cnt - o0, 0);
    if (stb_cyc.size() - s0 == 17) begin
      for (int i = 0; i < 17; i++) chk("t3_dat", stb_dat[s0 + i], 8'(8'h10 + i));
      chk("t3_span", stb_cyc[s0 + 16] - stb_cyc[s0], 16 * GAP);
    end

    // 20 writes during WAIT: four dropped
    do_reset(b);
    s0 = stb_cyc.size();
    o0 = ovf_cnt;
    wr(b + 10, 8'hC0);
    for (int i = 0; i < 20; i++) begin
      wr(b + 20 + i, 8'(8'h20 + i));
      if (i == 14) chk("t4_notfull", fifo_full, 1'b0);
      if (i == 15) chk("t4_full",    fifo_full, 1'b1);
      if (i == 16) chk("t4_ovf37",   overflow,  1'b1);
    end
    chk("t4_lvl", fifo_level, 16);
    goto(b + 12 + 16 * GAP + 20);
    chk("t4_ovfcnt", ovf_cnt - o0, 4);
    chk("t4_nstb", stb_cyc.size() - s0, 17);
    if (stb_cyc.size() - s0 == 17) begin
      chk("t4_dat0", stb_dat[s0], 8'hC0);
      for (int i = 0; i < 16; i++) chk("t4_dat", stb_dat[s0 + 1 + i], 8'(8'h20 + i));
    end

    // Write and pop together at full
    do_reset(b);
    s0 = stb_cyc.size();
    o0 = ovf_cnt;
    wr(b + 10, 8'hC0);
    for (int i = 0; i < 16; i++) wr(b + 20 + i, 8'(8'h40 + i));
    goto(b + 123);
    chk("t5_full123", fifo_full,  1'b1);
    wr(b + 123, 8'h99);
    chk("t5_lvl124",  fifo_level, 16);
    chk("t5_full124", fifo_full,  1'b1);
    chk("t5_en124",   uart_tx_enable, 1'b1);
    chk("t5_dat124",  uart_tx_data,   8'h40);
    goto(b + 125);
    chk("t5_ovf125",  overflow, 1'b0);
    goto(b + 12 + 17 * GAP + 20);
    chk("t5_ovfcnt", ovf_cnt - o0, 0);
    chk("t5_nstb", stb_cyc.size() - s0, 18);
    if (stb_cyc.size() - s0 == 18) chk("t5_last", stb_dat[s0 + 17], 8'h99);

    // Reset mid-frame with 5 queued
    do_reset(b);
    wr(b + 10, 8'hC0);
    for (int i = 0; i < 5; i++) wr(b + 20 + i, 8'(8'h60 + i));
    goto(b + 59);
    chk("t6_lvl59", fifo_level, 5);
    goto(b + 60);
    rst_n = 1'b0;
    goto(b + 61);
    rst_n = 1'b1;
    s0 = stb_cyc.size();
    chk("t6_data",  uart_tx_data,   8'h00);
    chk("t6_en",    uart_tx_enable, 1'b0);
    chk("t6_ovf",   overflow,       1'b0);
    chk("t6_empty", fifo_empty,     1'b1);
    chk("t6_full",  fifo_full,      1'b0);
    chk("t6_level", fifo_level,     '0);
    chk("t6_busy",  busy,           1'b0);
    goto(b + 400);
    chk("t6_nostb", stb_cyc.size() - s0, 0);
    wr(b + 400, 8'h5A);
    goto(b + 403);
    chk("t6_nstb", stb_cyc.size() - s0, 1);
    if (stb_cyc.size() - s0 == 1) begin
      chk("t6_stbcyc", stb_cyc[s0] - b, 402);
      chk("t6_dat",    stb_dat[s0],     8'h5A);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
